// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the button event classifier.
package button_pkg;

    // Classifier states
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PRESSED     = 3'd1,
        LONG_HELD   = 3'd2,
        WAIT_GAP    = 3'd3,
        SECOND_HELD = 3'd4
    } btn_state_t;

    // Width of the elapsed-ms counter: enough to hold the largest threshold
    function automatic int unsigned ms_cnt_width(input int unsigned long_ms,
                                                 input int unsigned gap_ms,
                                                 input int unsigned rep_ms);
        int unsigned m;
        m = long_ms;
        if (gap_ms > m) m = gap_ms;
        if (rep_ms > m) m = rep_ms;
        return $clog2(m + 1);
    endfunction

    // Terminal count of the millisecond prescaler
    function automatic int unsigned presc_last(input int unsigned clk_freq);
        return (clk_freq / 1000) - 1;
    endfunction

    // Prescaler counter width, never below one bit
    function automatic int unsigned presc_width(input int unsigned clk_freq);
        return ((clk_freq / 1000) > 1) ? $clog2(clk_freq / 1000) : 1;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond enable generator: ms_tick is a one-cycle
// strobe at each prescaler wrap. It is an enable, not a derived clock.
module ms_tick_gen
    import button_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic clk,
    input  logic rst_a_n,
    output logic ms_tick
);

    localparam int unsigned          PRESC_W    = presc_width(CLK_FREQ);
    localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(presc_last(CLK_FREQ));

    logic [PRESC_W-1:0] presc_cnt;

    // Prescaler counts 0..PRESC_LAST and flags the wrap one cycle later
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            presc_cnt <= '0;
            ms_tick   <= 1'b0;
        end else begin
            if (presc_cnt == PRESC_LAST) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + PRESC_W'(1);
            end
            ms_tick <= (presc_cnt == PRESC_LAST);
        end
    end

endmodule

// File: rtl/button_event_fsm.sv
// Classifies the debounced button level into one-clk event strobes:
// short press, long press, double press and optional auto-repeat.
// Build option: define BTN_REPEAT_EN to include the auto-repeat logic;
// otherwise repeat_pulse is tied low.
module button_event_fsm
    import button_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 50_000_000,
    parameter int unsigned LONG_PRESS_MS = 1000,
    parameter int unsigned DOUBLE_GAP_MS = 300,
    parameter int unsigned REPEAT_MS     = 200
) (
    input  logic clk,
    input  logic rst_a_n,
    input  logic button_in,
    output logic btn_level,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic repeat_pulse
);

    localparam int unsigned           MS_CNT_W   = ms_cnt_width(LONG_PRESS_MS, DOUBLE_GAP_MS, REPEAT_MS);
    localparam logic [MS_CNT_W-1:0]   LONG_LAST  = MS_CNT_W'(LONG_PRESS_MS - 1);
    localparam logic [MS_CNT_W-1:0]   GAP_LAST   = MS_CNT_W'(DOUBLE_GAP_MS - 1);
    localparam logic [MS_CNT_W-1:0]   MS_CNT_MAX = '1;
`ifdef BTN_REPEAT_EN
    localparam logic [MS_CNT_W-1:0]   REP_LAST   = MS_CNT_W'(REPEAT_MS - 1);
`endif

    logic                sync_meta;
    logic                btn_prev;
    logic                rise_c;
    logic                fall_c;
    logic                ms_tick;
    btn_state_t          state;
    btn_state_t          state_nxt;
    logic [MS_CNT_W-1:0] ms_cnt;
    logic [MS_CNT_W-1:0] ms_cnt_nxt;
    logic                short_nxt;
    logic                long_nxt;
    logic                double_nxt;
`ifdef BTN_REPEAT_EN
    logic                repeat_nxt;
`endif

    ms_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_ms_tick_gen (
        .clk     (clk),
        .rst_a_n (rst_a_n),
        .ms_tick (ms_tick)
    );

    // Two-flop synchronizer followed by the edge-detect register
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            sync_meta <= 1'b0;
            btn_level <= 1'b0;
            btn_prev  <= 1'b0;
        end else begin
            sync_meta <= button_in;
            btn_level <= sync_meta;
            btn_prev  <= btn_level;
        end
    end

    assign rise_c = btn_level & ~btn_prev;
    assign fall_c = ~btn_level & btn_prev;

    // Next-state, elapsed-ms counter and strobe decode
    always_comb begin
        state_nxt  = state;
        ms_cnt_nxt = ms_cnt;
        short_nxt  = 1'b0;
        long_nxt   = 1'b0;
        double_nxt = 1'b0;
`ifdef BTN_REPEAT_EN
        repeat_nxt = 1'b0;
`endif

        if (ms_tick && (ms_cnt != MS_CNT_MAX)) begin
            ms_cnt_nxt = ms_cnt + MS_CNT_W'(1);
        end

        case (state)
            IDLE: begin
                if (rise_c) begin
                    state_nxt = PRESSED;
                end
            end
            PRESSED: begin
                if (fall_c) begin
                    state_nxt = WAIT_GAP;
                end else if (ms_tick && (ms_cnt == LONG_LAST)) begin
                    long_nxt  = 1'b1;
                    state_nxt = LONG_HELD;
                end
            end
            LONG_HELD: begin
                if (fall_c) begin
                    state_nxt = IDLE;
                end
`ifdef BTN_REPEAT_EN
                else if (ms_tick && (ms_cnt == REP_LAST)) begin
                    repeat_nxt = 1'b1;
                    ms_cnt_nxt = '0;
                end
`endif
            end
            WAIT_GAP: begin
                // A new press beats a gap timeout landing in the same cycle
                if (rise_c) begin
                    double_nxt = 1'b1;
                    state_nxt  = SECOND_HELD;
                end else if (ms_tick && (ms_cnt == GAP_LAST)) begin
                    short_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            SECOND_HELD: begin
                if (fall_c) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state_nxt != state) begin
            ms_cnt_nxt = '0;
        end
    end

    // State, elapsed counter and registered strobes
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            state        <= IDLE;
            ms_cnt       <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
        end else begin
            state        <= state_nxt;
            ms_cnt       <= ms_cnt_nxt;
            short_press  <= short_nxt;
            long_press   <= long_nxt;
            double_press <= double_nxt;
        end
    end

`ifdef BTN_REPEAT_EN
    // Auto-repeat strobe register
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            repeat_pulse <= 1'b0;
        end else begin
            repeat_pulse <= repeat_nxt;
        end
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_fsm.sv
// Directed bench for button_event_fsm at 10 clk cycles per ms.
// Follows BTN_REPEAT_EN to pick the expected repeat behaviour.
`timescale 1ns/1ps
module tb_button_event_fsm;

    localparam int unsigned CLK_FREQ = 10_000;
    localparam int unsigned LONG_MS  = 20;
    localparam int unsigned GAP_MS   = 10;
    localparam int unsigned REP_MS   = 5;

    logic clk = 1'b0;
    logic rst_a_n;
    logic button_in;
    logic btn_level;
    logic short_press;
    logic long_press;
    logic double_press;
    logic repeat_pulse;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    int short_n = 0, long_n = 0, double_n = 0, repeat_n = 0, multi_n = 0;
    int short_cyc = 0, long_cyc = 0, double_cyc = 0;
    int rep_q[$];

    int s0, l0, d0, r0;

    button_event_fsm #(
        .CLK_FREQ      (CLK_FREQ),
        .LONG_PRESS_MS (LONG_MS),
        .DOUBLE_GAP_MS (GAP_MS),
        .REPEAT_MS     (REP_MS)
    ) dut (
        .clk          (clk),
        .rst_a_n      (rst_a_n),
        .button_in    (button_in),
        .btn_level    (btn_level),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_press (double_press),
        .repeat_pulse (repeat_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (short_press)  begin short_n++;  short_cyc  = cyc; end
        if (long_press)   begin long_n++;   long_cyc   = cyc; end
        if (double_press) begin double_n++; double_cyc = cyc; end
        if (repeat_pulse) begin repeat_n++; rep_q.push_back(cyc); end
        if ((int'(short_press) + int'(long_press) + int'(double_press) + int'(repeat_pulse)) > 1)
            multi_n++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_win(input string tag, input int val, input int lo, input int hi);
        check($sformatf("%s=%0d in [%0d,%0d]", tag, val, lo, hi), (val >= lo && val <= hi) ? 1 : 0, 1);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input logic v, output int at);
        @(negedge clk);
        button_in = v;
        at = cyc;
    endtask

    task automatic snap();
        s0 = short_n; l0 = long_n; d0 = double_n; r0 = repeat_n;
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_btn_level"},    int'(btn_level),    0);
        check({tag, "_short"},        int'(short_press),  0);
        check({tag, "_long"},         int'(long_press),   0);
        check({tag, "_double"},       int'(double_press), 0);
        check({tag, "_repeat"},       int'(repeat_pulse), 0);
    endtask

    initial begin
        int p, r, c_a, c_b, s_a, t_b, tmp, guard;

        rst_a_n   = 1'b0;
        button_in = 1'b0;
        step(3);
        check_outs_zero("reset");
        rst_a_n = 1'b1;
        step(5);

        // Reset in the middle of a hold; button still held on release
        set_btn(1'b1, p);
        step(100);
        rst_a_n = 1'b0;
        step(2);
        check_outs_zero("in_reset_a");
        step(20);
        check_outs_zero("in_reset_b");
        snap();
        rst_a_n = 1'b1;
        r = cyc;
        step(260);
        check("rst_hold_long_cnt", long_n - l0, 1);
        check_win("rst_hold_long_lat", long_cyc - r, 193, 203);
        check("rst_hold_level", int'(btn_level), 1);
        set_btn(1'b0, tmp);
        step(250);
        check("rst_hold_short_cnt", short_n - s0, 0);
        check("rst_hold_double_cnt", double_n - d0, 0);

        // Short press; also calibrates the gap-timeout phase
        snap();
        set_btn(1'b1, p);
        step(1);
        check("level_lag_1", int'(btn_level), 0);
        step(1);
        check("level_lag_2", int'(btn_level), 1);
        step(48);
        set_btn(1'b0, c_a);
        step(200);
        check("short_cnt", short_n - s0, 1);
        check_win("short_lat", short_cyc - c_a, 93, 103);
        check("short_long_cnt", long_n - l0, 0);
        check("short_double_cnt", double_n - d0, 0);
        check("short_repeat_cnt", repeat_n - r0, 0);
        s_a = short_cyc;

        // Hold 30 ms
        snap();
        set_btn(1'b1, p);
        step(300);
        set_btn(1'b0, tmp);
        step(250);
        check("hold30_long_cnt", long_n - l0, 1);
        check_win("hold30_long_lat", long_cyc - p, 193, 203);
        check("hold30_short_cnt", short_n - s0, 0);
        check("hold30_double_cnt", double_n - d0, 0);

        // Double press: 3 ms / 4 ms gap / 3 ms
        snap();
        set_btn(1'b1, tmp);
        step(30);
        set_btn(1'b0, tmp);
        step(40);
        set_btn(1'b1, p);
        step(30);
        set_btn(1'b0, tmp);
        step(250);
        check("dbl_cnt", double_n - d0, 1);
        check("dbl_lat", double_cyc - p, 3);
        check("dbl_short_cnt", short_n - s0, 0);
        check("dbl_long_cnt", long_n - l0, 0);

        // Hold 42 ms: long press and, when built, auto-repeat
        snap();
        rep_q.delete();
        set_btn(1'b1, p);
        step(420);
        set_btn(1'b0, tmp);
        step(250);
        check("hold42_long_cnt", long_n - l0, 1);
        check_win("hold42_long_lat", long_cyc - p, 193, 203);
        check("hold42_short_cnt", short_n - s0, 0);
`ifdef BTN_REPEAT_EN
        check("hold42_repeat_cnt", repeat_n - r0, 4);
        if (rep_q.size() == 4) begin
            check("repeat_first_gap", rep_q[0] - long_cyc, 50);
            check("repeat_span", rep_q[3] - rep_q[0], 150);
        end
`else
        check("hold42_repeat_cnt", repeat_n - r0, 0);
        check("hold42_repeat_level", int'(repeat_pulse), 0);
`endif

        // Rise in the same cycle as the gap-timeout tick
        snap();
        set_btn(1'b1, tmp);
        step(30);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (((cyc - c_a) % 10) != 0 && guard < 20);
        check("phase_align_found", ((cyc - c_a) % 10), 0);
        button_in = 1'b0;
        c_b = cyc;
        t_b = s_a - 1 + (c_b - c_a);
        step((t_b - 2) - c_b);
        button_in = 1'b1;
        step(30);
        set_btn(1'b0, tmp);
        step(250);
        check("race_double_cnt", double_n - d0, 1);
        check("race_double_cyc", double_cyc, t_b + 1);
        check("race_short_cnt", short_n - s0, 0);
        check("race_long_cnt", long_n - l0, 0);

        check("one_strobe_per_cycle", multi_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
